// File: rtl/rgb_fade_driver.sv
// Fading RGB LED driver: takes target colours over valid/ready and ramps each channel
// linearly toward its target, then renders each level as PWM on active-low pins.
module rgb_fade_driver #(
   parameter int unsigned STEP_CYCLES = 12000,
   parameter int unsigned PWM_BITS    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                col_valid,
   output logic                col_ready,
   input  logic [PWM_BITS-1:0] col_r,
   input  logic [PWM_BITS-1:0] col_g,
   input  logic [PWM_BITS-1:0] col_b,
   output logic                busy,
   output logic                RGB_R,
   output logic                RGB_G,
   output logic                RGB_B
);

   localparam int unsigned SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

   typedef enum logic {IDLE, FADING} state_t;

   state_t              state, state_nxt;
   logic [PWM_BITS-1:0] lvl_r, lvl_g, lvl_b;
   logic [PWM_BITS-1:0] tgt_r, tgt_g, tgt_b;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [SW-1:0]       step_cnt;
   logic                all_eq;
   logic                accept;

   // Compare-based step cannot overshoot or wrap at either end of the range.
   function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] lvl,
                                                       input logic [PWM_BITS-1:0] tgt);
      if (lvl < tgt)
         return lvl + PWM_BITS'(1);
      else if (lvl > tgt)
         return lvl - PWM_BITS'(1);
      else
         return lvl;
   endfunction

   assign all_eq    = (lvl_r == tgt_r) && (lvl_g == tgt_g) && (lvl_b == tgt_b);
   assign col_ready = (state == IDLE);
   assign busy      = (state == FADING);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (col_valid) begin
               accept    = 1'b1;
               state_nxt = FADING;
            end
         end
         FADING: begin
            if (all_eq)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_r    <= '0;
         lvl_g    <= '0;
         lvl_b    <= '0;
         tgt_r    <= '0;
         tgt_g    <= '0;
         tgt_b    <= '0;
         step_cnt <= '0;
      end else if (accept) begin
         tgt_r    <= col_r;
         tgt_g    <= col_g;
         tgt_b    <= col_b;
         step_cnt <= '0;
      end else if (state == FADING && !all_eq) begin
         if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
            lvl_r    <= step_toward(lvl_r, tgt_r);
            lvl_g    <= step_toward(lvl_g, tgt_g);
            lvl_b    <= step_toward(lvl_b, tgt_b);
         end else begin
            step_cnt <= step_cnt + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
         RGB_R   <= 1'b1;
         RGB_G   <= 1'b1;
         RGB_B   <= 1'b1;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
         RGB_R   <= ~(pwm_cnt < lvl_r);
         RGB_G   <= ~(pwm_cnt < lvl_g);
         RGB_B   <= ~(pwm_cnt < lvl_b);
      end
   end

endmodule

// File: tb/tb_rgb_fade_driver.sv
// Scoreboard bench for rgb_fade_driver: the driver queues expected fade length and pin
// duty per command; the monitor pops one entry each time busy falls and checks it.
module tb_rgb_fade_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       col_valid = 1'b0;
   logic       col_ready;
   logic [7:0] col_r = '0;
   logic [7:0] col_g = '0;
   logic [7:0] col_b = '0;
   logic       busy;
   logic       RGB_R, RGB_G, RGB_B;

   rgb_fade_driver #(.STEP_CYCLES(4), .PWM_BITS(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .col_valid(col_valid),
      .col_ready(col_ready),
      .col_r    (col_r),
      .col_g    (col_g),
      .col_b    (col_b),
      .busy     (busy),
      .RGB_R    (RGB_R),
      .RGB_G    (RGB_G),
      .RGB_B    (RGB_B)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned busy_len;
      logic        duty_chk;
      int unsigned dr, dg, db;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   errors   = 0;
   int   done_cnt = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic push(input int unsigned len, input logic duty,
                       input int unsigned r, input int unsigned g, input int unsigned b);
      exp_t e;
      e.busy_len = len;
      e.duty_chk = duty;
      e.dr = r;
      e.dg = g;
      e.db = b;
      exp_q.push_back(e);
   endtask

   // Called just after a negedge; returns just after the negedge following acceptance.
   task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      int n = 0;
      col_r = r;
      col_g = g;
      col_b = b;
      col_valid = 1'b1;
      while (!col_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!col_ready) chk("send_timeout", 0, 1);
      @(negedge clk);
      col_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("fade_done", done_cnt, target);
   endtask

   // Monitor: measures each busy run and, if asked, the settled low duty of each pin.
   initial begin : monitor
      int unsigned run = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            run = 0;
         end else if (busy) begin
            run++;
         end else if (run > 0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_fade", run, 0);
            end else begin
               exp_t e;
               int unsigned lr, lg, lb;
               e = exp_q.pop_front();
               chk("busy_len", run, e.busy_len);
               if (e.duty_chk) begin
                  lr = 0; lg = 0; lb = 0;
                  repeat (2) @(negedge clk);
                  repeat (256) begin
                     @(negedge clk);
                     if (!RGB_R) lr++;
                     if (!RGB_G) lg++;
                     if (!RGB_B) lb++;
                  end
                  chk("duty_r", lr, e.dr);
                  chk("duty_g", lg, e.dg);
                  chk("duty_b", lb, e.db);
               end
            end
            run = 0;
            done_cnt++;
         end
      end
   end

   initial begin : watchdog
      #1ms;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      int unsigned pin_bad, rdy_bad, busy_bad, gap;
      int          n;
      int          ndone;
      ndone = 0;

      repeat (3) @(negedge clk);
      chk("reset_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
      chk("reset_ready", col_ready, 1);
      chk("reset_busy", busy, 0);
      rst = 1'b0;

      pin_bad = 0; rdy_bad = 0; busy_bad = 0;
      repeat (1024) begin
         @(negedge clk);
         if ({RGB_R, RGB_G, RGB_B} != 3'b111) pin_bad++;
         if (!col_ready) rdy_bad++;
         if (busy) busy_bad++;
      end
      chk("idle_pins_off", pin_bad, 0);
      chk("idle_ready", rdy_bad, 0);
      chk("idle_busy", busy_bad, 0);

      // Full-scale red: 255 steps * 4 + 1.
      push(1021, 1'b1, 255, 0, 0);
      send(8'd255, 8'd0, 8'd0);
      chk("busy_after_accept", busy, 1);
      ndone++; wait_done(ndone);

      // Red down / green up concurrently; longest channel is 127 steps.
      push(509, 1'b1, 128, 64, 0);
      send(8'd128, 8'd64, 8'd0);
      ndone++; wait_done(ndone);

      // Held command during a fade must wait; first fade is 118 steps, then 245 to blue.
      push(473, 1'b0, 0, 0, 0);
      push(981, 1'b1, 0, 0, 255);
      send(8'd10, 8'd10, 8'd10);
      col_r = 8'd0; col_g = 8'd0; col_b = 8'd255;
      col_valid = 1'b1;
      rdy_bad = 0; n = 0;
      while (busy && n < 3000) begin
         if (col_ready) rdy_bad++;
         @(negedge clk);
         n++;
      end
      chk("ready_low_while_busy", rdy_bad, 0);
      gap = 0;
      while (!busy && gap < 10) begin
         @(negedge clk);
         gap++;
      end
      chk("held_cmd_idle_gap", gap, 1);
      col_valid = 1'b0;
      ndone += 2; wait_done(ndone);

      // Target equal to current levels: single busy cycle, duty unchanged.
      push(1, 1'b1, 0, 0, 255);
      send(8'd0, 8'd0, 8'd255);
      ndone++; wait_done(ndone);

      // Abort at lvl_r = 100: 100 steps after acceptance plus margin inside that step.
      send(8'd200, 8'd0, 8'd0);
      repeat (402) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_pins", {RGB_R, RGB_G, RGB_B}, 3'b111);
      chk("abort_busy", busy, 0);
      chk("abort_ready", col_ready, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", col_ready, 1);

      // Levels were cleared, so all channels need only 10 steps.
      push(41, 1'b1, 10, 10, 10);
      send(8'd10, 8'd10, 8'd10);
      ndone++; wait_done(ndone);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
